// File: rtl/mem_responder.sv
// mem_responder: word-addressed backing memory serving an instruction read
// port and a data read/write port. Each port runs its own IDLE/WAIT/RESP
// sequencer and answers a request a fixed number of cycles after accepting it.
// Read data is captured on the edge that enters RESP. A data write commits on
// the edge that leaves RESP. A read captured on that same edge gets the
// committing bytes forwarded to it, so it sees the new data.
module mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h6000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        err
);

    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAT_M1     = 4'(LATENCY - 1);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Backing array. Its contents survive reset.
    logic [31:0] r_mem [DEPTH_WORDS];

    // Instruction port state.
    state_t      r_i_state;
    logic [3:0]  r_i_cnt;
    logic [31:0] r_i_addr;
    logic [31:0] r_i_rdata;
    logic        r_i_resp;

    // Data port state. The request is latched at acceptance.
    state_t      r_d_state;
    logic [3:0]  r_d_cnt;
    logic [31:0] r_d_addr;
    logic [3:0]  r_d_wmask;
    logic [31:0] r_d_wdata;
    logic        r_d_we;
    logic        r_d_both;
    logic [31:0] r_d_rdata;
    logic        r_d_resp;

    logic        r_err;

    // Instruction port combinational view.
    logic             w_i_accept;
    logic             w_i_enter;
    logic [31:0]      w_i_tgt_addr;
    logic [31:0]      w_i_off;
    logic             w_i_inr;
    logic [IDX_W-1:0] w_i_idx;
    logic             w_i_fwd;
    logic [31:0]      w_i_word;

    // Data port combinational view.
    logic             w_d_accept;
    logic             w_d_enter;
    logic [31:0]      w_d_tgt_addr;
    logic             w_d_tgt_we;
    logic             w_d_tgt_both;
    logic [31:0]      w_d_off;
    logic             w_d_inr;
    logic [IDX_W-1:0] w_d_idx;
    logic             w_d_fwd;
    logic [31:0]      w_d_word;

    // Write commit, driven by the data port while it sits in RESP.
    logic [31:0]      w_wr_off;
    logic             w_wr_inr;
    logic [IDX_W-1:0] w_wr_idx;
    logic             w_wr_commit;

    assign imem_rdata = r_i_rdata;
    assign imem_resp  = r_i_resp;
    assign dmem_rdata = r_d_rdata;
    assign dmem_resp  = r_d_resp;
    assign err        = r_err;

    // A port is free to accept a request in IDLE, and also in its RESP cycle.
    assign w_i_accept = ((r_i_state == ST_IDLE) || (r_i_state == ST_RESP)) && (imem_rmask != 4'd0);
    assign w_d_accept = ((r_d_state == ST_IDLE) || (r_d_state == ST_RESP)) &&
                        ((dmem_rmask != 4'd0) || (dmem_wmask != 4'd0));

    // RESP is entered from the last WAIT cycle. At single-cycle latency it is
    // entered directly from acceptance.
    assign w_i_enter = ((LATENCY == 1) && w_i_accept) || ((r_i_state == ST_WAIT) && (r_i_cnt == 4'd1));
    assign w_d_enter = ((LATENCY == 1) && w_d_accept) || ((r_d_state == ST_WAIT) && (r_d_cnt == 4'd1));

    // The request that is about to enter RESP comes from the live inputs when
    // it is accepted on this same edge; otherwise it comes from the latched copy.
    assign w_i_tgt_addr = w_i_accept ? imem_addr : r_i_addr;
    assign w_d_tgt_addr = w_d_accept ? dmem_addr : r_d_addr;
    assign w_d_tgt_we   = w_d_accept ? (dmem_wmask != 4'd0) : r_d_we;
    assign w_d_tgt_both = w_d_accept ? ((dmem_wmask != 4'd0) && (dmem_rmask != 4'd0)) : r_d_both;

    // Range decode. Because offset < 4*DEPTH, an address below the base wraps
    // to a large offset and is rejected as well.
    assign w_i_off  = w_i_tgt_addr - BASE_ADDR;
    assign w_i_inr  = (w_i_tgt_addr >= BASE_ADDR) && (w_i_off < SPAN_BYTES);
    assign w_i_idx  = w_i_off[IDX_W+1:2];

    assign w_d_off  = w_d_tgt_addr - BASE_ADDR;
    assign w_d_inr  = (w_d_tgt_addr >= BASE_ADDR) && (w_d_off < SPAN_BYTES);
    assign w_d_idx  = w_d_off[IDX_W+1:2];

    assign w_wr_off    = r_d_addr - BASE_ADDR;
    assign w_wr_inr    = (r_d_addr >= BASE_ADDR) && (w_wr_off < SPAN_BYTES);
    assign w_wr_idx    = w_wr_off[IDX_W+1:2];
    assign w_wr_commit = !rst && (r_d_state == ST_RESP) && r_d_we && w_wr_inr;

    assign w_i_fwd = w_wr_commit && (w_wr_idx == w_i_idx);
    assign w_d_fwd = w_wr_commit && (w_wr_idx == w_d_idx);

    // Per-byte read mux. A write committing on the capture edge is forwarded.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign w_i_word[gi*8 +: 8] = (w_i_fwd && r_d_wmask[gi]) ? r_d_wdata[gi*8 +: 8]
                                                                    : r_mem[w_i_idx][gi*8 +: 8];
            assign w_d_word[gi*8 +: 8] = (w_d_fwd && r_d_wmask[gi]) ? r_d_wdata[gi*8 +: 8]
                                                                    : r_mem[w_d_idx][gi*8 +: 8];
        end
    endgenerate

    // Commit enabled bytes of a data write as the data port leaves RESP.
    always_ff @(posedge clk) begin
        if (w_wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (r_d_wmask[b]) begin
                    r_mem[w_wr_idx][b*8 +: 8] <= r_d_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Instruction port sequencer with registered resp and read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_state <= ST_IDLE;
            r_i_cnt   <= 4'd0;
            r_i_addr  <= 32'd0;
            r_i_rdata <= 32'd0;
            r_i_resp  <= 1'b0;
        end else begin
            r_i_resp <= w_i_enter;
            if (w_i_enter) begin
                r_i_rdata <= w_i_inr ? w_i_word : 32'd0;
            end
            case (r_i_state)
                ST_WAIT: begin
                    if (r_i_cnt == 4'd1) begin
                        r_i_state <= ST_RESP;
                        r_i_cnt   <= 4'd0;
                    end else begin
                        r_i_cnt <= r_i_cnt - 4'd1;
                    end
                end
                default: begin
                    if (w_i_accept) begin
                        r_i_addr <= imem_addr;
                        if (LATENCY == 1) begin
                            r_i_state <= ST_RESP;
                        end else begin
                            r_i_state <= ST_WAIT;
                            r_i_cnt   <= LAT_M1;
                        end
                    end else begin
                        r_i_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Data port sequencer. Read data is loaded only for reads; writes leave it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_state <= ST_IDLE;
            r_d_cnt   <= 4'd0;
            r_d_addr  <= 32'd0;
            r_d_wmask <= 4'd0;
            r_d_wdata <= 32'd0;
            r_d_we    <= 1'b0;
            r_d_both  <= 1'b0;
            r_d_rdata <= 32'd0;
            r_d_resp  <= 1'b0;
        end else begin
            r_d_resp <= w_d_enter;
            if (w_d_enter && !w_d_tgt_we) begin
                r_d_rdata <= w_d_inr ? w_d_word : 32'd0;
            end
            case (r_d_state)
                ST_WAIT: begin
                    if (r_d_cnt == 4'd1) begin
                        r_d_state <= ST_RESP;
                        r_d_cnt   <= 4'd0;
                    end else begin
                        r_d_cnt <= r_d_cnt - 4'd1;
                    end
                end
                default: begin
                    if (w_d_accept) begin
                        r_d_addr  <= dmem_addr;
                        r_d_wmask <= dmem_wmask;
                        r_d_wdata <= dmem_wdata;
                        r_d_we    <= (dmem_wmask != 4'd0);
                        r_d_both  <= (dmem_wmask != 4'd0) && (dmem_rmask != 4'd0);
                        if (LATENCY == 1) begin
                            r_d_state <= ST_RESP;
                        end else begin
                            r_d_state <= ST_WAIT;
                            r_d_cnt   <= LAT_M1;
                        end
                    end else begin
                        r_d_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Sticky error flag. It is raised together with the offending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((w_i_enter && !w_i_inr) || (w_d_enter && (!w_d_inr || w_d_tgt_both))) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder. It drives randomized and directed traffic and
// checks it against a transaction-level model. In the model, each port holds
// at most one pending request, which is due LATENCY cycles after acceptance.
// In a due cycle the instruction read sees memory before any data write from
// that same cycle, and the data write is applied afterwards.
module tb_mem_responder;

    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;
    localparam logic [31:0] BASE  = 32'h6000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr = '0;
    logic [3:0]  imem_rmask = '0;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr = '0;
    logic [3:0]  dmem_rmask = '0;
    logic [3:0]  dmem_wmask = '0;
    logic [31:0] dmem_wdata = '0;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        err;

    mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_iresp = 0;

    // Reference model state.
    logic [31:0] mdl [DEPTH];
    bit          ip_v, dp_v, dp_we, dp_both;
    int          ip_due, dp_due;
    logic [31:0] ip_addr, dp_addr, dp_wd;
    logic [3:0]  dp_wm;
    logic [31:0] exp_ird = '0, exp_drd = '0;
    bit          exp_err = 1'b0;
    logic [31:0] last_ird = '0, last_drd = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cyc %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    function automatic bit m_inr(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a >= BASE) && ((off >> 2) < 32'(DEPTH));
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        return int'(off);
    endfunction

    // Resolve the model's due transactions for the current cycle, then compare all outputs.
    task automatic eval_cycle();
        bit ei, ed;
        ei = 1'b0;
        ed = 1'b0;
        if (ip_v && ip_due == cyc) begin
            ei = 1'b1;
            ip_v = 1'b0;
            if (m_inr(ip_addr)) exp_ird = mdl[m_idx(ip_addr)];
            else begin exp_ird = 32'h0; exp_err = 1'b1; end
        end
        if (dp_v && dp_due == cyc) begin
            ed = 1'b1;
            dp_v = 1'b0;
            if (dp_both) exp_err = 1'b1;
            if (!m_inr(dp_addr)) begin
                exp_err = 1'b1;
                if (!dp_we) exp_drd = 32'h0;
            end else if (dp_we) begin
                for (int b = 0; b < 4; b++)
                    if (dp_wm[b]) mdl[m_idx(dp_addr)][b*8 +: 8] = dp_wd[b*8 +: 8];
            end else begin
                exp_drd = mdl[m_idx(dp_addr)];
            end
        end
        check("imem_resp", {31'd0, imem_resp}, {31'd0, ei});
        check("dmem_resp", {31'd0, dmem_resp}, {31'd0, ed});
        check("imem_rdata", imem_rdata, exp_ird);
        check("dmem_rdata", dmem_rdata, exp_drd);
        check("err", {31'd0, err}, {31'd0, exp_err});
        if (imem_resp) begin
            last_ird = imem_rdata;
            n_iresp++;
            $display("cyc %0d imem resp addr=%h rdata=%h err=%0b", cyc, ip_addr, imem_rdata, err);
        end
        if (dmem_resp) begin
            last_drd = dmem_rdata;
            $display("cyc %0d dmem resp addr=%h we=%0b rdata=%h err=%0b", cyc, dp_addr, dp_we, dmem_rdata, err);
        end
    endtask

    // Drive one cycle of inputs, register any model acceptance, then advance and check.
    task automatic step(input logic [31:0] ia, input logic [3:0] irm,
                        input logic [31:0] da, input logic [3:0] drm,
                        input logic [3:0] dwm, input logic [31:0] dwd);
        imem_addr  = ia;
        imem_rmask = irm;
        dmem_addr  = da;
        dmem_rmask = drm;
        dmem_wmask = dwm;
        dmem_wdata = dwd;
        if (irm != 4'd0 && !ip_v) begin
            ip_v = 1'b1; ip_due = cyc + LAT; ip_addr = ia;
        end
        if ((drm != 4'd0 || dwm != 4'd0) && !dp_v) begin
            dp_v = 1'b1; dp_due = cyc + LAT; dp_addr = da;
            dp_we = (dwm != 4'd0); dp_both = (dwm != 4'd0) && (drm != 4'd0);
            dp_wm = dwm; dp_wd = dwd;
        end
        @(posedge clk);
        #1;
        cyc++;
        eval_cycle();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(32'h0, 4'h0, 32'h0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic do_reset();
        imem_rmask = 4'h0; dmem_rmask = 4'h0; dmem_wmask = 4'h0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_imem_resp", {31'd0, imem_resp}, 32'd0);
        check("rst_dmem_resp", {31'd0, dmem_resp}, 32'd0);
        check("rst_imem_rdata", imem_rdata, 32'd0);
        check("rst_dmem_rdata", dmem_rdata, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        ip_v = 1'b0; dp_v = 1'b0;
        exp_ird = '0; exp_drd = '0; exp_err = 1'b0;
        cyc = 0;
    endtask

    task automatic wr_word(input int idx, input logic [3:0] wm, input logic [31:0] d);
        step(BASE + 32'(idx * 4), 4'h0, BASE + 32'(idx * 4), 4'h0, wm, d);
        idle(LAT - 1);
    endtask

    function automatic logic [31:0] win_addr();
        return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] any_addr();
        int s;
        s = $urandom_range(0, 9);
        case (s)
            0: return 32'h5FFF_FFFC;
            1: return BASE + 32'(DEPTH * 4);
            2: return BASE + 32'((DEPTH - 1) * 4);
            default: return win_addr();
        endcase
    endfunction

    task automatic rand_traffic(input int n, input bit allow_err);
        logic [31:0] ia, da;
        logic [3:0]  irm, drm, dwm;
        int          op;
        for (int k = 0; k < n; k++) begin
            ia  = allow_err ? any_addr() : win_addr();
            da  = allow_err ? any_addr() : win_addr();
            irm = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            op  = $urandom_range(0, 3);
            drm = 4'h0;
            dwm = 4'h0;
            if (op == 1) drm = 4'($urandom_range(1, 15));
            if (op >= 2) dwm = 4'($urandom_range(1, 15));
            if (allow_err && op == 3 && $urandom_range(0, 4) == 0) drm = 4'($urandom_range(1, 15));
            step(ia, irm, da, drm, dwm, $urandom);
        end
        idle(LAT + 1);
    endtask

    initial begin
        logic [31:0] saved;
        int          base_cnt;

        do_reset();

        // Preload the test window and the last word.
        for (int i = 0; i < 16; i++) wr_word(i, 4'hF, (i == 6) ? 32'h0 : $urandom);
        wr_word(DEPTH - 1, 4'hF, 32'hA5A5_0FF0);

        // Full write followed by an instruction read of the same word.
        wr_word(4, 4'hF, 32'hDEAD_BEEF);
        idle(1);
        step(BASE + 32'h10, 4'hF, 32'h0, 4'h0, 4'h0, 32'h0);
        idle(LAT);
        check("req034_rdata", last_ird, 32'hDEAD_BEEF);

        // Partial byte write.
        wr_word(5, 4'hF, 32'h1122_3344);
        wr_word(5, 4'b0010, 32'h0000_AB00);
        step(32'h0, 4'h0, BASE + 32'h14, 4'hF, 4'h0, 32'h0);
        idle(LAT);
        check("req035_rdata", last_drd, 32'h1122_AB44);

        // Simultaneous instruction read and data write of one word.
        step(BASE + 32'h18, 4'h1, BASE + 32'h18, 4'h0, 4'hF, 32'hCAFE_F00D);
        idle(LAT);
        check("req038_old", last_ird, 32'h0);
        step(BASE + 32'h18, 4'h8, 32'h0, 4'h0, 4'h0, 32'h0);
        idle(LAT);
        check("req038_new", last_ird, 32'hCAFE_F00D);

        // Held instruction request: one response per LAT cycles.
        base_cnt = n_iresp;
        for (int k = 0; k < 6 * LAT; k++) step(win_addr(), 4'hF, 32'h0, 4'h0, 4'h0, 32'h0);
        check("req036_count", 32'(n_iresp - base_cnt), 32'd6);
        idle(LAT);

        rand_traffic(300, 1'b0);

        // A reset right after a write is accepted abandons the write.
        saved = mdl[7];
        step(32'h0, 4'h0, BASE + 32'h1C, 4'h0, 4'hF, ~saved);
        do_reset();
        step(32'h0, 4'h0, BASE + 32'h1C, 4'h1, 4'h0, 32'h0);
        idle(LAT);
        check("req039_word", last_drd, saved);

        // An out-of-range read sets the sticky error flag.
        step(32'h5FFF_FFFC, 4'hF, 32'h0, 4'h0, 4'h0, 32'h0);
        idle(LAT);
        check("req037_rdata", last_ird, 32'h0);
        check("req037_err", {31'd0, err}, 32'd1);
        rand_traffic(40, 1'b0);
        check("req037_sticky", {31'd0, err}, 32'd1);

        do_reset();
        rand_traffic(250, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, 1024, number of 32-bit words in the backing array.
REQ-002 Parameter: LATENCY, 2, cycles from request acceptance to resp; legal range 1..15.
REQ-003 Parameter: BASE_ADDR, 32'h6000_0000, byte address of word 0; word-aligned.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 imem_addr  input  32  instruction read byte address.
REQ-007 imem_rmask  input  4  instruction read request; nonzero means a read is requested.
REQ-008 imem_rdata  output  32  instruction read data.
REQ-009 imem_resp  output  1  one-cycle pulse marking valid imem_rdata.
REQ-010 dmem_addr  input  32  data byte address.
REQ-011 dmem_rmask  input  4  data read request; nonzero means read.
REQ-012 dmem_wmask  input  4  data write byte enables; nonzero means write.
REQ-013 dmem_wdata  input  32  write data; byte i written when wmask[i]=1.
REQ-014 dmem_rdata  output  32  data read data.
REQ-015 dmem_resp  output  1  one-cycle pulse completing a data read or write.
REQ-016 err  output  1  sticky error flag.

Function
REQ-017 Each port (imem, dmem) SHALL have an independent FSM: IDLE, WAIT, RESP.
REQ-018 A port SHALL accept a request when in IDLE or RESP and its mask is nonzero; addr, masks and wdata are latched at acceptance; the requester need not hold them afterwards.
REQ-019 Accept -> resp exactly LATENCY cycles later; LATENCY=1 goes directly to RESP next cycle, otherwise WAIT with down-counter of LATENCY-1 cycles.
REQ-020 resp SHALL be high for exactly the single cycle spent in RESP; from RESP, next state is WAIT/RESP if a new request is accepted that cycle, else IDLE (back-to-back throughput: one request per LATENCY cycles).
REQ-021 Requests arriving in WAIT SHALL be ignored (not queued).
REQ-022 Word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
REQ-023 Reads SHALL return the full 32-bit word read from the array in the RESP cycle, regardless of rmask bit pattern.
REQ-024 Writes SHALL commit only the enabled bytes in the RESP cycle; dmem_rdata is unchanged for writes.
REQ-025 rdata outputs SHALL hold their last value outside RESP cycles.
REQ-026 Out-of-range address (below BASE_ADDR or index >= DEPTH_WORDS): read returns 32'h0, write dropped, resp still issued, err set.
REQ-027 dmem_rmask and dmem_wmask both nonzero at acceptance: treated as write, err set.
REQ-028 Same-cycle imem RESP read and dmem RESP write to the same word: imem returns pre-write data (read-before-write); dmem write then visible to later reads.
REQ-029 dmem RESP read of a word written by an earlier dmem RESP SHALL see the new data (no forwarding issue as commits are sequential).
REQ-030 err, once set, SHALL stay high until rst.

Reset
REQ-031 On rst: both FSMs IDLE, counters 0, imem_resp=0, dmem_resp=0, imem_rdata=0, dmem_rdata=0, err=0.
REQ-032 Array contents SHALL NOT be reset; the bench preloads them through dmem writes.
REQ-033 rst during WAIT/RESP SHALL abandon the pending request: no resp issued, no array write.

Verification
REQ-034 LATENCY=2: dmem write addr 0x6000_0010 wmask 4'hF wdata 0xDEADBEEF at cycle 0 -> dmem_resp at cycle 2; imem read same addr at cycle 3 -> imem_resp at cycle 5, imem_rdata=0xDEADBEEF.
REQ-035 Partial write wmask 4'b0010 wdata 0x0000AB00 onto 0x11223344 -> later read returns 0x1122AB44.
REQ-036 imem_rmask held 4'hF with addr changing on each resp, LATENCY=2 -> imem_resp every 2 cycles, each rdata matching the addr latched at its acceptance; requests during WAIT ignored.
REQ-037 imem read at addr 0x5FFF_FFFC -> imem_resp with rdata 0x0, err=1 and stays 1 across later legal transactions until rst.
REQ-038 Same-cycle imem read and dmem write (0x0 -> 0xCAFEF00D) reaching RESP together at same word -> imem_rdata=0x0; subsequent read returns 0xCAFEF00D.
REQ-039 rst asserted one cycle after dmem write acceptance -> no dmem_resp, word unchanged on later read, all outputs 0 after reset.
